writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue_if.sv | 43 ++++
 rtl/writeback_queue.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/writeback_queue_if.sv
// Result-lane and register-file write bundle for writeback_queue.
// master drives lanes/stall; slave (the queue) drives in_ready, writes, count.
interface writeback_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid0;
    logic [4:0]    in_rd0;
    logic [31:0]   in_data0;
    logic          in_valid1;
    logic [4:0]    in_rd1;
    logic [31:0]   in_data1;
    logic          in_ready;
    logic          stall;
    logic          we1;
    logic [4:0]    waddr1;
    logic [31:0]   wdata1;
    logic          we2;
    logic [4:0]    waddr2;
    logic [31:0]   wdata2;
    logic [CW-1:0] count;

    modport master (
        output in_valid0, in_rd0, in_data0,
        output in_valid1, in_rd1, in_data1,
        output stall,
        input  in_ready,
        input  we1, waddr1, wdata1,
        input  we2, waddr2, wdata2,
        input  count
    );

    modport slave (
        input  in_valid0, in_rd0, in_data0,
        input  in_valid1, in_rd1, in_data1,
        input  stall,
        output in_ready,
        output we1, waddr1, wdata1,
        output we2, waddr2, wdata2,
        output count
    );
endinterface

// File: rtl/writeback_queue.sv
// Two-lane in-order writeback queue feeding a dual-port register file.
// Ports: clk, rst_n (async, active low), bus (writeback_queue_if.slave).
module writeback_queue #(
    parameter int DEPTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    writeback_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic          we1_q;
    logic [4:0]    waddr1_q;
    logic [31:0]   wdata1_q;
    logic          we2_q;
    logic [4:0]    waddr2_q;
    logic [31:0]   wdata2_q;

    logic          ready;
    logic          enq_both;
    logic          enq_one;
    logic          pop_two;
    logic          pop_one;
    logic [CW-1:0] enq_n;
    logic [CW-1:0] deq_n;
    logic [PW-1:0] head_p1;
    logic [PW-1:0] tail_p1;
    logic [4:0]    rd_a;
    logic [4:0]    rd_b;
    logic [31:0]   data_a;
    logic [31:0]   data_b;
    logic [4:0]    one_rd;
    logic [31:0]   one_data;

    // Need room for a full pair, so ready depends only on registered count.
    assign ready = (CW'(DEPTH) - count_q) >= CW'(2);

    assign head_p1 = head_q + PW'(1);
    assign tail_p1 = tail_q + PW'(1);

    assign rd_a   = rd_mem[head_q];
    assign rd_b   = rd_mem[head_p1];
    assign data_a = data_mem[head_q];
    assign data_b = data_mem[head_p1];

    always_comb begin
        enq_both = 1'b0;
        enq_one  = 1'b0;
        one_rd   = bus.in_rd1;
        one_data = bus.in_data1;
        if (ready) begin
            enq_both = bus.in_valid0 & bus.in_valid1;
            enq_one  = bus.in_valid0 ^ bus.in_valid1;
        end
        if (bus.in_valid0) begin
            one_rd   = bus.in_rd0;
            one_data = bus.in_data0;
        end
    end

    always_comb begin
        pop_two = 1'b0;
        pop_one = 1'b0;
        if (!bus.stall) begin
            pop_two = count_q >= CW'(2);
            pop_one = count_q == CW'(1);
        end
    end

    always_comb begin
        enq_n = '0;
        if (enq_both) begin
            enq_n = CW'(2);
        end else if (enq_one) begin
            enq_n = CW'(1);
        end
    end

    always_comb begin
        deq_n = '0;
        if (pop_two) begin
            deq_n = CW'(2);
        end else if (pop_one) begin
            deq_n = CW'(1);
        end
    end

    // Storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (enq_both) begin
            rd_mem[tail_q]    <= bus.in_rd0;
            data_mem[tail_q]  <= bus.in_data0;
            rd_mem[tail_p1]   <= bus.in_rd1;
            data_mem[tail_p1] <= bus.in_data1;
        end else if (enq_one) begin
            rd_mem[tail_q]    <= one_rd;
            data_mem[tail_q]  <= one_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(deq_n);
            tail_q  <= tail_q + PW'(enq_n);
            count_q <= count_q + enq_n - deq_n;
        end
    end

    // Same-address pair: only the younger write survives, on port 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we1_q    <= 1'b0;
            waddr1_q <= '0;
            wdata1_q <= '0;
            we2_q    <= 1'b0;
            waddr2_q <= '0;
            wdata2_q <= '0;
        end else begin
            we1_q <= 1'b0;
            we2_q <= 1'b0;
            if (pop_two) begin
                we1_q    <= (rd_a != 5'd0) && (rd_a != rd_b);
                waddr1_q <= rd_a;
                wdata1_q <= data_a;
                we2_q    <= rd_b != 5'd0;
                waddr2_q <= rd_b;
                wdata2_q <= data_b;
            end else if (pop_one) begin
                we1_q    <= rd_a != 5'd0;
                waddr1_q <= rd_a;
                wdata1_q <= data_a;
            end
        end
    end

    assign bus.in_ready = ready;
    assign bus.count    = count_q;
    assign bus.we1      = we1_q;
    assign bus.waddr1   = waddr1_q;
    assign bus.wdata1   = wdata1_q;
    assign bus.we2      = we2_q;
    assign bus.waddr2   = waddr2_q;
    assign bus.wdata2   = wdata2_q;
endmodule
